axil8_rr_arbiter: RTL and testbench
===================================

Name: axil8_rr_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer in front of the 8-bit AXI4-Lite slave: the single bus master for that slave.
- Each requester issues a simple command (req/we/addr/wdata). The block serialises commands onto the AW/W/B or AR/R channels and returns ack, read data and an error flag to the winning requester.
- Sits between the pin-level control logic and the AXI-Lite slave in the top-level wrapper.

Parameters:
ADDR_WIDTH, 1, slave address width
DATA_WIDTH, 8, data width (multiple of 8)
TIMEOUT_CYCLES, 15, max wait cycles per handshake (used only with the optional feature)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
req  in  2  request per requester (bit i = requester i)
we  in  2  1 = write, 0 = read, per requester
addr  in  2*ADDR_WIDTH  address, requester i in slice i
wdata  in  2*DATA_WIDTH  write data, requester i in slice i
ack  out  2  one-cycle completion pulse to granted requester
rdata  out  DATA_WIDTH  read data, valid with ack of a read
err  out  2  one-cycle error pulse, coincident with ack
M_AWADDR / M_ARADDR  out  ADDR_WIDTH each  latched address
M_AWVALID / M_WVALID / M_ARVALID  out  1 each  channel valids
M_AWREADY / M_WREADY / M_ARREADY  in  1 each  slave readies
M_WDATA  out  DATA_WIDTH  latched write data
M_WSTRB  out  DATA_WIDTH/8  all ones
M_BVALID / M_RVALID  in  1 each  slave response valids
M_BREADY / M_RREADY  out  1 each  response readies
M_BRESP / M_RRESP  in  2 each  slave responses
M_RDATA  in  DATA_WIDTH  slave read data

Behaviour:
- Clock is ACLK. Reset is synchronous, active-low, on ARESETN: on the first edge with ARESETN=0, state goes to IDLE and a mid-transaction reset abandons the transaction with no ack.
- Reset values: all outputs 0 except M_WSTRB = all ones; last_grant = 1, so requester 0 wins the first tie.
- States and master outputs:
  - IDLE: no master outputs.
  - AW: M_AWVALID=1.
  - W: M_WVALID=1.
  - B: M_BREADY=1.
  - AR: M_ARVALID=1.
  - R: M_RREADY=1.
  - DONE: no master outputs.
- Master outputs are decoded from registered state only; no combinational path from req to M_*.
- IDLE: if any req bit is set, grant it. If both are set, grant the requester != last_grant.
  - On the grant edge, latch we, addr and wdata of the winner into M_AWADDR/M_ARADDR/M_WDATA.
  - Go to AW if we=1, else AR.
- Transitions advance on the edge where the handshake completes:
  - AW → W on M_AWREADY.
  - W → B on M_WREADY.
  - B → DONE on M_BVALID, capturing err = (M_BRESP != 00).
  - AR → R on M_ARREADY.
  - R → DONE on M_RVALID, capturing rdata = M_RDATA and err = (M_RRESP != 00).
- DONE lasts exactly one cycle:
  - ack[g]=1 and err[g]=captured value; the other bit stays 0.
  - last_grant <= g; next state IDLE.
- rdata holds its last captured value until the next read completes. Writes leave it unchanged.
- Latency with an always-ready slave, req first high in cycle N: write ack in N+4, read ack in N+3. The minimum gap between consecutive grants is one IDLE cycle.
- Requesters hold req/we/addr/wdata until ack. Inputs are sampled only on the grant edge. A req dropped after grant does not cancel the transaction; ack still pulses.
- A requester re-asserting immediately after its ack loses to a waiting peer (strict alternation under contention).
- Only one transaction is outstanding at any time; AW and W are never asserted together.

Optional Feature:
- Macro AXIL_ARB_TIMEOUT_EN.
- Defined: a per-state wait counter, cleared on every state change, counts cycles spent in AW/W/B/AR/R. When it reaches TIMEOUT_CYCLES, go to DONE with err[g]=1 and ack[g]=1, and drop all master valids/readies. For a timed-out read, rdata is unchanged.
- Undefined: no counter is instantiated; the block waits indefinitely; err reflects only BRESP/RRESP. Ports are identical in both builds.

Test Plan:
- Reset: ARESETN=0 for 2 cycles with req=11 → ack=00, all M_* valids/readies 0, M_WSTRB=1; after release, requester 0 granted first.
- Single write: req=01, we=01, addr0=0, wdata0=8'h3C → M_AWVALID in N+1, M_WVALID with M_WDATA=3C in N+2, ack=01 in N+4, err=00; a following read of addr 1 returns rdata=8'hC3 in N+3 of that read.
- Contention: req=11 held, requester 0 writes 8'h0F, requester 1 reads addr 1 → grants alternate 0,1,0,1 across 4 acks; requester 1's read returns 8'hF0.
- Back-pressure: M_AWREADY held 0 for 5 cycles, then 1 → M_AWVALID stays high all 5 cycles with stable M_AWADDR; ack arrives 5 cycles later than nominal.
- Reset mid-write: ARESETN=0 while in state W → next cycle M_WVALID=0, ack never pulses for that request, state IDLE.
- Timeout (AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15): M_RVALID stuck 0 after AR → ack=err=1 for the granted bit after 15 cycles in R, M_RREADY drops, rdata unchanged.

Source files
------------

// File: rtl/axil8_rr_arbiter.sv
// Two-requester round-robin command sequencer acting as the sole AXI4-Lite master.
// Optional handshake watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil8_rr_arbiter #(
  parameter int ADDR_WIDTH     = 1,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              err,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic                    M_AWVALID,
  output logic                    M_WVALID,
  output logic                    M_ARVALID,
  input  logic                    M_AWREADY,
  input  logic                    M_WREADY,
  input  logic                    M_ARREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  input  logic                    M_BVALID,
  input  logic                    M_RVALID,
  output logic                    M_BREADY,
  output logic                    M_RREADY,
  input  logic [1:0]              M_BRESP,
  input  logic [1:0]              M_RRESP,
  input  logic [DATA_WIDTH-1:0]   M_RDATA
);

  // state   | meaning
  // S_IDLE  | waiting for a request, arbitration happens here
  // S_AW    | write address offered
  // S_W     | write data offered
  // S_B     | waiting for write response
  // S_AR    | read address offered
  // S_R     | waiting for read data
  // S_DONE  | one-cycle ack/err pulse to the granted requester
  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state;
  state_t                  state_adv;
  state_t                  state_next;
  logic                    gnt;
  logic                    last_grant;
  logic                    err_q;
  logic                    timeout;
  logic                    pick;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    pick      = (req == 2'b11) ? ~last_grant : req[1];
    sel_we    = pick ? we[1] : we[0];
    sel_addr  = pick ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
    sel_wdata = pick ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          wait_state;

  assign wait_state = (state == S_AW) || (state == S_W) || (state == S_B) ||
                      (state == S_AR) || (state == S_R);

  // Down-counter reloaded on every state change; zero marks the last allowed cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tmo_cnt <= TMO_LOAD;
    end else if (state_next != state) begin
      tmo_cnt <= TMO_LOAD;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_adv = state;
    case (state)
      S_IDLE:  if (|req) state_adv = sel_we ? S_AW : S_AR;
      S_AW:    if (M_AWREADY) state_adv = S_W;
      S_W:     if (M_WREADY) state_adv = S_B;
      S_B:     if (M_BVALID) state_adv = S_DONE;
      S_AR:    if (M_ARREADY) state_adv = S_R;
      S_R:     if (M_RVALID) state_adv = S_DONE;
      S_DONE:  state_adv = S_IDLE;
      default: state_adv = S_IDLE;
    endcase
    state_next = state_adv;
    timeout    = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
    if (wait_state && (tmo_cnt == '0) && (state_adv == state)) begin
      state_next = S_DONE;
      timeout    = 1'b1;
    end
`endif
  end

  always_comb begin
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    ack       = 2'b00;
    case (state)
      S_AW:    M_AWVALID = 1'b1;
      S_W:     M_WVALID  = 1'b1;
      S_B:     M_BREADY  = 1'b1;
      S_AR:    M_ARVALID = 1'b1;
      S_R:     M_RREADY  = 1'b1;
      S_DONE:  ack       = gnt ? 2'b10 : 2'b01;
      default: ;
    endcase
    err = ack & {2{err_q}};
  end

  assign M_WSTRB = '1;

  // Command capture on the grant edge, response capture on the completing edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      rdata      <= '0;
      M_AWADDR   <= '0;
      M_ARADDR   <= '0;
      M_WDATA    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt <= pick;
            if (sel_we) begin
              M_AWADDR <= sel_addr;
              M_WDATA  <= sel_wdata;
            end else begin
              M_ARADDR <= sel_addr;
            end
          end
        end
        S_B: if (M_BVALID) err_q <= |M_BRESP;
        S_R: begin
          if (M_RVALID) begin
            rdata <= M_RDATA;
            err_q <= |M_RRESP;
          end
        end
        S_DONE:  last_grant <= gnt;
        default: ;
      endcase
      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil8_rr_arbiter.sv
// Bench for axil8_rr_arbiter: small register slave model, vector table and scoreboard.
module tb_axil8_rr_arbiter;

  logic       ACLK;
  logic       ARESETN;
  logic [1:0] req, we, addr;
  logic [15:0] wdata;
  logic [1:0] ack, err;
  logic [7:0] rdata;
  logic [0:0] M_AWADDR, M_ARADDR;
  logic       M_AWVALID, M_WVALID, M_ARVALID;
  logic       M_AWREADY, M_WREADY, M_ARREADY;
  logic [7:0] M_WDATA;
  logic [0:0] M_WSTRB;
  logic       M_BVALID, M_RVALID, M_BREADY, M_RREADY;
  logic [1:0] M_BRESP, M_RRESP;
  logic [7:0] M_RDATA;

  axil8_rr_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err),
    .M_AWADDR(M_AWADDR), .M_ARADDR(M_ARADDR),
    .M_AWVALID(M_AWVALID), .M_WVALID(M_WVALID), .M_ARVALID(M_ARVALID),
    .M_AWREADY(M_AWREADY), .M_WREADY(M_WREADY), .M_ARREADY(M_ARREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_BVALID(M_BVALID), .M_RVALID(M_RVALID), .M_BREADY(M_BREADY), .M_RREADY(M_RREADY),
    .M_BRESP(M_BRESP), .M_RRESP(M_RRESP), .M_RDATA(M_RDATA)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave: register 0 is writable, register 1 reads back its complement.
  logic       aw_rdy = 1'b1;
  logic       r_vld  = 1'b1;
  logic [1:0] resp   = 2'b00;
  logic [7:0] reg0;
  assign M_AWREADY = aw_rdy;
  assign M_WREADY  = 1'b1;
  assign M_ARREADY = 1'b1;
  assign M_BVALID  = 1'b1;
  assign M_RVALID  = r_vld;
  assign M_BRESP   = resp;
  assign M_RRESP   = resp;
  assign M_RDATA   = M_ARADDR[0] ? ~reg0 : reg0;
  always @(posedge ACLK) begin
    if (!ARESETN) reg0 <= 8'h00;
    else if (M_WVALID && M_WREADY && M_AWADDR[0] == 1'b0) reg0 <= M_WDATA;
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] rdata;
    int         cyc;
    string      name;
  } exp_t;
  exp_t sb[$];

  logic mon_en = 1'b0;
  always @(negedge ACLK) begin
    if (mon_en && ack !== 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack=%b err=%b at cycle %0d, required no ack", ack, err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_ack"}, 32'(ack), 32'(e.ack));
        chk({e.name, "_err"}, 32'(err), 32'(e.err));
        chk({e.name, "_rdata"}, 32'(rdata), 32'(e.rdata));
        if (e.cyc >= 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [7:0] rd,
                      input int c, input string nm);
    exp_t x;
    x.ack = a; x.err = e; x.rdata = rd; x.cyc = c; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge ACLK);
      if (ack !== 2'b00) got++;
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d acks, required %0d", nm, got, n);
    end
  endtask

  // Active requester r gets the command; the other slice carries inverted junk.
  task automatic drive(input int r, input logic w, input logic a, input logic [7:0] wd);
    req   = 2'b00;
    we    = ~{w, w};
    addr  = ~{a, a};
    wdata = ~{wd, wd};
    req[r]           = 1'b1;
    we[r]            = w;
    addr[r]          = a;
    wdata[r*8 +: 8]  = wd;
  endtask

  task automatic run_row(input int r, input logic w, input logic a, input logic [7:0] wd,
                         input logic [1:0] rs, input logic e, input logic [7:0] rd,
                         input string nm);
    logic [1:0] bit_r;
    @(posedge ACLK); #1;
    resp = rs;
    drive(r, w, a, wd);
    bit_r = (r == 1) ? 2'b10 : 2'b01;
    push(bit_r, e ? bit_r : 2'b00, rd, cyc + (w ? 4 : 3), nm);
    wait_acks(1, 40, nm);
  endtask

  typedef struct {
    int         r;
    logic       w;
    logic       a;
    logic [7:0] wd;
    logic [1:0] rs;
    logic       e;
    logic [7:0] rd;
  } vec_t;
  vec_t vt[9];

  initial begin
    int s;
    vt[0] = '{0, 1'b1, 1'b0, 8'h3C, 2'b00, 1'b0, 8'hF0};
    vt[1] = '{0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'hC3};
    vt[2] = '{1, 1'b1, 1'b0, 8'h55, 2'b00, 1'b0, 8'hC3};
    vt[3] = '{1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h55};
    vt[4] = '{1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'hAA};
    vt[5] = '{0, 1'b1, 1'b0, 8'hA5, 2'b10, 1'b1, 8'hAA};
    vt[6] = '{0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 8'hA5};
    vt[7] = '{1, 1'b1, 1'b1, 8'h77, 2'b00, 1'b0, 8'hA5};
    vt[8] = '{0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'h5A};

    // Reset with both requesting: requester 0 writes 0F, requester 1 reads addr 1.
    ARESETN = 1'b0;
    req     = 2'b11;
    we      = 2'b01;
    addr    = 2'b10;
    wdata   = {8'h00, 8'h0F};
    for (int i = 0; i < 2; i++) begin
      @(posedge ACLK);
      mon_en = 1'b1;
      @(negedge ACLK);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_valids", 32'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}), 32'd0);
      chk("rst_wstrb", 32'(M_WSTRB), 32'd1);
    end
    ARESETN = 1'b1;
    s = cyc;
    push(2'b01, 2'b00, 8'h00, s + 4,  "cont0");
    push(2'b10, 2'b00, 8'hF0, s + 8,  "cont1");
    push(2'b01, 2'b00, 8'hF0, s + 13, "cont2");
    push(2'b10, 2'b00, 8'hF0, s + 17, "cont3");
    wait_acks(4, 60, "cont");
    @(posedge ACLK); #1;
    req = 2'b00;

    for (int i = 0; i < 9; i++)
      run_row(vt[i].r, vt[i].w, vt[i].a, vt[i].wd, vt[i].rs, vt[i].e, vt[i].rd,
              $sformatf("vec%0d", i));

    // Back-pressure: AWREADY low for five AW cycles.
    @(posedge ACLK); #1;
    resp   = 2'b00;
    aw_rdy = 1'b0;
    drive(0, 1'b1, 1'b1, 8'h3C);
    push(2'b01, 2'b00, 8'h5A, cyc + 9, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      chk("bp_awvalid", 32'(M_AWVALID), 32'd1);
      chk("bp_awaddr", 32'(M_AWADDR), 32'd1);
      chk("bp_wvalid", 32'(M_WVALID), 32'd0);
    end
    @(posedge ACLK); #1;
    aw_rdy = 1'b1;
    wait_acks(1, 20, "bp");

    // Reset while in W: transaction abandoned, no ack.
    @(posedge ACLK); #1;
    drive(0, 1'b1, 1'b0, 8'h99);
    @(posedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mw_wvalid_pre", 32'(M_WVALID), 32'd1);
    chk("mw_wdata", 32'(M_WDATA), 32'h99);
    ARESETN = 1'b0;
    req     = 2'b00;
    @(negedge ACLK);
    chk("mw_wvalid_post", 32'(M_WVALID), 32'd0);
    chk("mw_ack", 32'(ack), 32'd0);
    chk("mw_rdata_reset", 32'(rdata), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    run_row(1, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'hFF, "post_rst_rd");

`ifdef AXIL_ARB_TIMEOUT_EN
    @(posedge ACLK); #1;
    r_vld = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    push(2'b01, 2'b01, 8'hFF, cyc + 17, "tmo");
    wait_acks(1, 40, "tmo");
    chk("tmo_rready", 32'(M_RREADY), 32'd0);
    @(posedge ACLK); #1;
    req   = 2'b00;
    r_vld = 1'b1;
`endif

    @(posedge ACLK); #1;
    req = 2'b00;
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
